// File: rtl/tick_bcd_timer.sv
// Three-digit BCD event timer advanced by prescaled tick pulses from an upstream decade counter.
// The alarm and wrap pulses are registered with the count, so they appear on the same edge as bcd_out.
module tick_bcd_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load_en,
  input  logic [11:0] load_val,
  input  logic [11:0] alarm_val,
  output logic [11:0] bcd_out,
  output logic        running,
  output logic        wrap,
  output logic        alarm
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  localparam logic [3:0] PresLast = 4'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic [3:0]  presc_q, presc_d;
  logic [11:0] count_q, count_d;
  logic        wrap_q, wrap_d;
  logic        alarm_q, alarm_d;

  logic [11:0] count_inc;
  logic        inc_wrap;
  logic        load_ok;
  logic        count_tick;

  // BCD increment with digit carry; 999 rolls to 000.
  always_comb begin
    count_inc = count_q;
    inc_wrap  = 1'b0;
    if (count_q[3:0] == 4'd9) begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] == 4'd9) begin
        count_inc[7:4] = 4'd0;
        if (count_q[11:8] == 4'd9) begin
          count_inc[11:8] = 4'd0;
          inc_wrap        = 1'b1;
        end else begin
          count_inc[11:8] = count_q[11:8] + 4'd1;
        end
      end else begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end
    end else begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end
  end

  assign load_ok    = (load_val[3:0] <= 4'd9) && (load_val[7:4] <= 4'd9) &&
                      (load_val[11:8] <= 4'd9);
  // A tick in the start cycle is dropped because state_q is not yet StRun.
  assign count_tick = (state_q == StRun) && tick && !clear && !load_en;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    alarm_d = 1'b0;

    if (clear) begin
      count_d = 12'h000;
      presc_d = 4'd0;
    end else if (load_en) begin
      if (load_ok) begin
        count_d = load_val;
        presc_d = 4'd0;
      end
    end else if (count_tick) begin
      if (presc_q == PresLast) begin
        presc_d = 4'd0;
        count_d = count_inc;
        wrap_d  = inc_wrap;
        alarm_d = (count_inc == alarm_val);
      end else begin
        presc_d = presc_q + 4'd1;
      end
    end

    if (clear) begin
      state_d = StIdle;
    end else if (!load_en) begin
      if (stop) begin
        if (state_q == StRun) state_d = StPause;
      end else if (start) begin
        if (state_q != StRun) state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      presc_q <= 4'd0;
      count_q <= 12'h000;
      wrap_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      alarm_q <= alarm_d;
    end
  end

  assign bcd_out = count_q;
  assign running = (state_q == StRun);
  assign wrap    = wrap_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Bench for tick_bcd_timer: PRESCALE=1 and PRESCALE=3 instances share stimulus, checked
// cycle by cycle against an integer-arithmetic reference model through a scoreboard queue.
module tb_tick_bcd_timer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tick, start, stop, clear, load_en;
  logic [11:0] load_val, alarm_val;
  logic [11:0] bcd1, bcd3;
  logic        run1, run3, wrap1, wrap3, alarm1, alarm3;

  int checks = 0;
  int errors = 0;
  int alarm_seen = 0;

  typedef struct packed {
    logic [11:0] bcd1;
    logic        run;
    logic        wrap1;
    logic        alarm1;
    logic [11:0] bcd3;
    logic        wrap3;
    logic        alarm3;
  } exp_t;

  exp_t sbq[$];

  // Reference model: 0 idle, 1 run, 2 pause; counts held as plain integers 0..999.
  int ms = 0;
  int mc1 = 0, mp1 = 0, mc3 = 0, mp3 = 0;

  always #5 clk = ~clk;

  tick_bcd_timer #(.PRESCALE(1)) dut1 (
    .clk(clk), .rstn(rstn), .tick(tick), .start(start), .stop(stop), .clear(clear),
    .load_en(load_en), .load_val(load_val), .alarm_val(alarm_val),
    .bcd_out(bcd1), .running(run1), .wrap(wrap1), .alarm(alarm1)
  );

  tick_bcd_timer #(.PRESCALE(3)) dut3 (
    .clk(clk), .rstn(rstn), .tick(tick), .start(start), .stop(stop), .clear(clear),
    .load_en(load_en), .load_val(load_val), .alarm_val(alarm_val),
    .bcd_out(bcd3), .running(run3), .wrap(wrap3), .alarm(alarm3)
  );

  function automatic logic [11:0] int2bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic int bcd2int(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic void chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  task automatic model_one(input int p, inout int c, inout int pr, output logic w,
                           output logic a);
    w = 1'b0;
    a = 1'b0;
    if (!rstn) begin
      c  = 0;
      pr = 0;
    end else if (clear) begin
      c  = 0;
      pr = 0;
    end else if (load_en) begin
      if (load_val[3:0] <= 9 && load_val[7:4] <= 9 && load_val[11:8] <= 9) begin
        c  = bcd2int(load_val);
        pr = 0;
      end
    end else if (ms == 1 && tick) begin
      pr = pr + 1;
      if (pr == p) begin
        pr = 0;
        c  = (c + 1) % 1000;
        w  = (c == 0);
        a  = (int2bcd(c) === alarm_val);
      end
    end
  endtask

  task automatic model_step(output exp_t e);
    logic w1, a1, w3, a3;
    model_one(1, mc1, mp1, w1, a1);
    model_one(3, mc3, mp3, w3, a3);
    if (!rstn || clear) ms = 0;
    else if (!load_en) begin
      if (stop) begin
        if (ms == 1) ms = 2;
      end else if (start) ms = 1;
    end
    e.bcd1   = int2bcd(mc1);
    e.bcd3   = int2bcd(mc3);
    e.run    = (ms == 1);
    e.wrap1  = w1;
    e.alarm1 = a1;
    e.wrap3  = w3;
    e.alarm3 = a3;
  endtask

  // Drive one cycle of stimulus, predict, then compare just after the edge.
  task automatic step(input logic t, input logic st, input logic sp, input logic cl,
                      input logic ld, input logic [11:0] lv);
    exp_t e;
    tick = t; start = st; stop = sp; clear = cl; load_en = ld; load_val = lv;
    model_step(e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 12'd0, 12'd1);
    end else begin
      e = sbq.pop_front();
      chk("bcd_p1", bcd1, e.bcd1);
      chk("running_p1", {11'd0, run1}, {11'd0, e.run});
      chk("wrap_p1", {11'd0, wrap1}, {11'd0, e.wrap1});
      chk("alarm_p1", {11'd0, alarm1}, {11'd0, e.alarm1});
      chk("bcd_p3", bcd3, e.bcd3);
      chk("running_p3", {11'd0, run3}, {11'd0, e.run});
      chk("wrap_p3", {11'd0, wrap3}, {11'd0, e.wrap3});
      chk("alarm_p3", {11'd0, alarm3}, {11'd0, e.alarm3});
    end
    if (alarm1) alarm_seen++;
  endtask

  initial begin
    rstn = 1'b0; alarm_val = 12'h999;
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load_en = 1'b0; load_val = 12'h000;
    @(posedge clk);
    #1;

    // Reset dominates commands and tick.
    step(1, 1, 0, 0, 1, 12'h123);
    step(1, 1, 0, 0, 0, 12'h000);
    chk("reset_bcd", bcd1, 12'h000);
    chk("reset_running", {11'd0, run1}, 12'd0);
    rstn = 1'b1;

    // Start (tick in same cycle ignored), then 12 ticks.
    step(1, 1, 0, 0, 0, 12'h000);
    chk("start_tick_ignored", bcd1, 12'h000);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 0, 12'h000);
      step(0, 0, 0, 0, 0, 12'h000);
    end
    chk("twelve_ticks_bcd", bcd1, 12'h012);
    chk("twelve_ticks_running", {11'd0, run1}, 12'd1);
    chk("twelve_ticks_p3", bcd3, 12'h004);

    // Load 998, two ticks: 999 then 000 with a single-cycle wrap.
    step(0, 0, 0, 1, 0, 12'h000);
    step(0, 0, 0, 0, 1, 12'h998);
    chk("load_998", bcd1, 12'h998);
    chk("load_keeps_idle", {11'd0, run1}, 12'd0);
    step(0, 1, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, 12'h000);
    chk("wrap_999", bcd1, 12'h999);
    chk("wrap_not_yet", {11'd0, wrap1}, 12'd0);
    step(1, 0, 0, 0, 0, 12'h000);
    chk("wrap_000", bcd1, 12'h000);
    chk("wrap_pulse", {11'd0, wrap1}, 12'd1);
    step(0, 0, 0, 0, 0, 12'h000);
    chk("wrap_one_cycle", {11'd0, wrap1}, 12'd0);

    // Prescale 3: 7 ticks give 002 with remainder 1.
    step(0, 0, 0, 1, 0, 12'h000);
    step(0, 1, 0, 0, 0, 12'h000);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 12'h000);
    chk("presc3_seven", bcd3, 12'h002);
    step(1, 0, 0, 0, 0, 12'h000);
    chk("presc3_eight", bcd3, 12'h002);
    step(1, 0, 0, 0, 0, 12'h000);
    chk("presc3_nine", bcd3, 12'h003);

    // Alarm at 005 fires once; loading 005 does not fire it.
    alarm_val = 12'h005;
    step(0, 0, 0, 1, 0, 12'h000);
    step(0, 1, 0, 0, 0, 12'h000);
    alarm_seen = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 12'h000);
    chk("alarm_count_5", bcd1, 12'h005);
    chk("alarm_once", 12'(alarm_seen), 12'd1);
    step(0, 0, 0, 0, 1, 12'h005);
    chk("load_no_alarm", {11'd0, alarm1}, 12'd0);
    chk("load_keeps_run", {11'd0, run1}, 12'd1);
    alarm_val = 12'h999;

    // stop+start in RUN pauses; ticks then ignored; stop+start in PAUSE stays paused.
    step(1, 1, 1, 0, 0, 12'h000);
    chk("stopstart_pause", {11'd0, run1}, 12'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 12'h000);
    chk("pause_holds", bcd1, 12'h006);
    step(1, 1, 1, 0, 0, 12'h000);
    chk("pause_stays", {11'd0, run1}, 12'd0);
    step(0, 0, 0, 1, 1, 12'h123);
    chk("clear_over_load", bcd1, 12'h000);
    step(1, 1, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, 12'h000);
    chk("restart_count", bcd1, 12'h001);

    // Non-BCD load value is ignored.
    step(0, 0, 0, 0, 1, 12'h9A5);
    chk("bad_load_ignored", bcd1, 12'h001);

    // Reset mid-count at 437.
    step(0, 0, 0, 0, 1, 12'h437);
    step(1, 0, 0, 0, 0, 12'h000);
    chk("midcount_438", bcd1, 12'h438);
    rstn = 1'b0;
    step(1, 1, 0, 0, 0, 12'h000);
    chk("midreset_bcd", bcd1, 12'h000);
    chk("midreset_running", {11'd0, run1}, 12'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 12'h000);
    chk("postreset_idle", bcd1, 12'h000);
    step(0, 1, 0, 0, 0, 12'h000);
    step(1, 0, 0, 0, 0, 12'h000);
    chk("postreset_start", bcd1, 12'h001);

    // Constrained-random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [11:0] lv;
      rstn = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 49) == 0) alarm_val = int2bcd(int'($urandom_range(0, 999)));
      lv = ($urandom_range(0, 3) == 0) ? 12'($urandom) : int2bcd(int'($urandom_range(0, 999)));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0), lv);
    end
    rstn = 1'b1;
    chk("scoreboard_drained", 12'(sbq.size()), 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
